load_store_unit: RTL and testbench

//  Memory-access stage placed directly downstream of the execute ALU. Takes ALUResult as the

---
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store stage: one access per start on a word-wide req/ready port.
// Ports: start/is_load/is_store/funct3/addr/wdata in; busy/done/rdata/err out; mem_* port.
module load_store_unit #(
  parameter int W       = 32,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_load,
  input  logic         is_store,
  input  logic [2:0]   funct3,
  input  logic [W-1:0] addr,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rdata,
  output logic [1:0]   err,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [3:0]   mem_wstrb,
  output logic [W-1:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t       state, state_nx;
  logic [2:0]   f3_q;
  logic [1:0]   off_q;
  logic         ld_q;
  logic [7:0]   cnt;
  logic         illegal;
  logic         misal;
  logic         tmo;
  logic [3:0]   st_strb;
  logic [W-1:0] st_data;
  logic [W-1:0] sh;
  logic [W-1:0] ld_ext;

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign mem_req = (state == ACCESS);
  assign tmo     = (cnt == 8'(TIMEOUT - 1));

  always_comb begin
    illegal = (is_load == is_store)
            | (is_load  & !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
            | (is_store & !(funct3 inside {3'b000, 3'b001, 3'b010}));
    misal   = ((funct3[1:0] == 2'b01) & addr[0])
            | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  end

  always_comb begin
    st_strb = 4'b1111;
    st_data = wdata;
    unique case (funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << addr[1:0];
        st_data = {2{wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = wdata;
      end
    endcase
  end

  // Selected lane is shifted down to bit 0 before extension.
  always_comb begin
    sh     = mem_rdata >> {off_q, 3'b000};
    ld_ext = mem_rdata;
    unique case (f3_q)
      3'b000:  ld_ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ld_ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ld_ext = {24'd0, sh[7:0]};
      3'b101:  ld_ext = {16'd0, sh[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (illegal || misal) state_nx = DONE;
          else                  state_nx = ACCESS;
        end
      end
      ACCESS: begin
        // ready beats the terminal count
        if (mem_ready || tmo) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata     <= '0;
      err       <= 2'b00;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= '0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      ld_q      <= 1'b0;
      cnt       <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt <= 8'd0;
            if (illegal) begin
              err <= 2'b11;
            end else if (misal) begin
              err <= 2'b01;
            end else begin
              err       <= 2'b00;
              ld_q      <= is_load;
              f3_q      <= funct3;
              off_q     <= addr[1:0];
              mem_we    <= is_store;
              mem_addr  <= {addr[W-1:2], 2'b00};
              mem_wstrb <= is_store ? st_strb : 4'b0000;
              mem_wdata <= is_store ? st_data : '0;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            err <= 2'b00;
            if (ld_q) rdata <= ld_ext;
          end else begin
            cnt <= cnt + 8'd1;
            if (tmo) err <= 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit.
// Drives and samples on the falling edge; DUT acts on the rising edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  load_store_unit #(.W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start),
    .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a falling edge; returns in the cycle after the start edge.
  task automatic launch(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    is_load  = ld;
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Cycles counted from the cycle after the start edge (1 = immediate done).
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 40) begin
      step();
      cyc++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'b000; addr = '0; wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    step(); step();
    chk("rst_busy",  {31'd0, busy},    32'd0);
    chk("rst_done",  {31'd0, done},    32'd0);
    chk("rst_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_rdata", rdata,            32'd0);
    chk("rst_err",   {30'd0, err},     32'd0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    rst = 1'b0;
    mem_ready = 1'b1;
    step();
    chk("idle_ready_ignored", {31'd0, busy}, 32'd0);

    // LB sign extension from the top lane
    mem_rdata = 32'h8000_0000;
    launch(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    chk("lb_req",   {31'd0, mem_req}, 32'd1);
    chk("lb_addr",  mem_addr,         32'h100);
    chk("lb_we",    {31'd0, mem_we},  32'd0);
    chk("lb_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("lb_busy",  {31'd0, busy},    32'd1);
    wait_done(n);
    chk("lb_lat",   n,                32'd2);
    chk("lb_rdata", rdata,            32'hFFFF_FF80);
    chk("lb_err",   {30'd0, err},     32'd0);
    chk("lb_done_req", {31'd0, mem_req}, 32'd0);
    step();
    chk("lb_done_pulse", {31'd0, done}, 32'd0);
    chk("lb_idle",  {31'd0, busy},    32'd0);
    chk("lb_hold",  rdata,            32'hFFFF_FF80);

    // LHU upper half
    mem_rdata = 32'hBEEF_1234;
    launch(1'b1, 1'b0, 3'b101, 32'h202, 32'h0);
    wait_done(n);
    chk("lhu_rdata", rdata, 32'h0000_BEEF);
    step();

    // LH sign extension
    mem_rdata = 32'h8001_0000;
    launch(1'b1, 1'b0, 3'b001, 32'h202, 32'h0);
    wait_done(n);
    chk("lh_rdata", rdata, 32'hFFFF_8001);
    step();

    // LBU lane 1
    mem_rdata = 32'h0000_A500;
    launch(1'b1, 1'b0, 3'b100, 32'h101, 32'h0);
    wait_done(n);
    chk("lbu_rdata", rdata, 32'h0000_00A5);
    step();

    // LW pass-through
    mem_rdata = 32'h1234_5678;
    launch(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    wait_done(n);
    chk("lw_rdata", rdata, 32'h1234_5678);
    step();

    // SH upper half
    launch(1'b0, 1'b1, 3'b001, 32'h302, 32'h0000_ABCD);
    chk("sh_we",    {31'd0, mem_we},  32'd1);
    chk("sh_addr",  mem_addr,         32'h300);
    chk("sh_wstrb", {28'd0, mem_wstrb}, 32'hC);
    chk("sh_wdata", mem_wdata,        32'hABCD_ABCD);
    wait_done(n);
    chk("sh_err",   {30'd0, err},     32'd0);
    chk("sh_rdata_kept", rdata,       32'h1234_5678);
    step();

    // SB lane 1
    launch(1'b0, 1'b1, 3'b000, 32'h301, 32'h1234_5677);
    chk("sb_wstrb", {28'd0, mem_wstrb}, 32'h2);
    chk("sb_wdata", mem_wdata,        32'h7777_7777);
    wait_done(n);
    step();

    // Misaligned LW: no request, immediate done
    launch(1'b1, 1'b0, 3'b010, 32'h401, 32'h0);
    chk("mis_req",  {31'd0, mem_req}, 32'd0);
    chk("mis_done", {31'd0, done},    32'd1);
    chk("mis_err",  {30'd0, err},     32'd1);
    chk("mis_rdata", rdata,           32'h1234_5678);
    step();
    chk("mis_idle", {31'd0, busy},    32'd0);

    // Illegal: both load and store
    launch(1'b1, 1'b1, 3'b010, 32'h400, 32'h0);
    chk("ill_both_req", {31'd0, mem_req}, 32'd0);
    chk("ill_both_err", {30'd0, err},     32'd3);
    step();

    // Illegal: store funct3=100
    launch(1'b0, 1'b1, 3'b100, 32'h400, 32'h0);
    chk("ill_st_err", {30'd0, err}, 32'd3);
    step();

    // Timeout on SW with a start pulse mid-wait
    mem_ready = 1'b0;
    launch(1'b0, 1'b1, 3'b010, 32'h500, 32'hDEAD_BEEF);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      start = (n == 5);
      if (n == 5) begin
        is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
      end
      step();
    end
    start = 1'b0;
    chk("tmo_req_cycles", n, 32'd15);
    chk("tmo_done", {31'd0, done}, 32'd1);
    chk("tmo_err",  {30'd0, err},  32'd2);
    chk("tmo_rdata", rdata,        32'h1234_5678);
    step();
    chk("tmo_no_queue", {31'd0, busy}, 32'd0);

    // Ready on the terminal-count cycle wins
    launch(1'b0, 1'b1, 3'b010, 32'h504, 32'h0);
    for (int i = 1; i <= 15; i++) begin
      mem_ready = (i == 15);
      step();
    end
    mem_ready = 1'b0;
    chk("tc_ready_done", {31'd0, done}, 32'd1);
    chk("tc_ready_err",  {30'd0, err},  32'd0);
    step();

    // Reset during ACCESS
    launch(1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
    chk("rst_mid_req_before", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_req",  {31'd0, mem_req}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy},    32'd0);
    chk("rst_mid_done", {31'd0, done},    32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    mem_ready = 1'b1;
    mem_rdata = 32'hC300_0000;
    launch(1'b1, 1'b0, 3'b100, 32'h603, 32'h0);
    wait_done(n);
    chk("post_rst_lat",   n,            32'd2);
    chk("post_rst_rdata", rdata,        32'h0000_00C3);
    chk("post_rst_err",   {30'd0, err}, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
